// File: rtl/rx_frame_fsm.sv
// UART RX frame state machine: start check, LSB-first data, parity, stop.
// Ports: clk/rst, AcqSig_i, Rx_Synch_i, RxBit_i, DataAck_i in;
//        State_o, Data_o, DataValid_o, ParityErr_o, FrameErr_o, Overrun_o out.
module rx_frame_fsm #(
   parameter int OVERSAMPLE = 16,
   parameter int DATA_BITS  = 8,
   parameter int PARITY_EN  = 0,
   parameter int PARITY_ODD = 0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       AcqSig_i,
   input  logic       Rx_Synch_i,
   input  logic       RxBit_i,
   output logic [4:0] State_o,
   output logic [7:0] Data_o,
   output logic       DataValid_o,
   input  logic       DataAck_i,
   output logic       ParityErr_o,
   output logic       FrameErr_o,
   output logic       Overrun_o
);

   localparam int SW = $clog2(OVERSAMPLE);

   typedef enum logic [4:0] {
      IDLE   = 5'b00000,
      START  = 5'b00001,
      DATA   = 5'b00010,
      PARITY = 5'b00100,
      STOP   = 5'b01000
   } state_e;

   state_e        state_q;
   logic [SW-1:0] samp_cnt_q;
   logic [SW-1:0] samp_cnt_d;
   logic [2:0]    bit_cnt_q;
   logic [7:0]    shreg_q;
   logic          par_q;
   logic [7:0]    data_q;
   logic          valid_q;
   logic          perr_q;
   logic          ferr_q;
   logic          ovr_q;

   logic mid_tick;
   logic end_tick;
   logic last_bit;
   logic perr_d;

   assign mid_tick   = AcqSig_i && (samp_cnt_q == SW'(OVERSAMPLE / 2));
   assign end_tick   = AcqSig_i && (samp_cnt_q == SW'(OVERSAMPLE - 1));
   assign samp_cnt_d = end_tick ? '0 : samp_cnt_q + SW'(1);
   assign last_bit   = (bit_cnt_q == 3'(DATA_BITS - 1));

   // Unused upper word bits stay 0, so a full-width XOR is the data XOR.
   assign perr_d = (PARITY_EN != 0) &&
                   (par_q != ((^shreg_q) ^ (PARITY_ODD != 0)));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         samp_cnt_q <= '0;
         bit_cnt_q  <= '0;
         shreg_q    <= '0;
         par_q      <= 1'b0;
         data_q     <= '0;
         valid_q    <= 1'b0;
         perr_q     <= 1'b0;
         ferr_q     <= 1'b0;
         ovr_q      <= 1'b0;
      end else begin
         if (DataAck_i && valid_q) begin
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
         end
         unique case (state_q)
            IDLE: begin
               // The sync strobe is itself acquisition pulse 0.
               if (Rx_Synch_i) begin
                  state_q    <= START;
                  samp_cnt_q <= SW'(1);
                  bit_cnt_q  <= '0;
                  shreg_q    <= '0;
                  par_q      <= 1'b0;
               end
            end
            START: begin
               if (AcqSig_i) samp_cnt_q <= samp_cnt_d;
               if (mid_tick && RxBit_i) begin
                  state_q    <= IDLE;
                  samp_cnt_q <= '0;
               end else if (end_tick) begin
                  state_q   <= DATA;
                  bit_cnt_q <= '0;
               end
            end
            DATA: begin
               if (AcqSig_i) samp_cnt_q <= samp_cnt_d;
               if (mid_tick) shreg_q[bit_cnt_q] <= RxBit_i;
               if (end_tick) begin
                  if (last_bit)
                     state_q <= (PARITY_EN != 0) ? PARITY : STOP;
                  else
                     bit_cnt_q <= bit_cnt_q + 3'd1;
               end
            end
            PARITY: begin
               if (AcqSig_i) samp_cnt_q <= samp_cnt_d;
               if (mid_tick) par_q <= RxBit_i;
               if (end_tick) state_q <= STOP;
            end
            STOP: begin
               if (AcqSig_i) samp_cnt_q <= samp_cnt_d;
               // Complete at the stop mid-point so a new start edge
               // arriving in the second half bit is still caught.
               if (mid_tick) begin
                  state_q    <= IDLE;
                  samp_cnt_q <= '0;
                  data_q     <= shreg_q;
                  ferr_q     <= !RxBit_i;
                  perr_q     <= perr_d;
                  valid_q    <= 1'b1;
                  ovr_q      <= valid_q && !DataAck_i;
               end
            end
            default: begin
               state_q    <= IDLE;
               samp_cnt_q <= '0;
            end
         endcase
      end
   end

   assign State_o     = state_q;
   assign Data_o      = data_q;
   assign DataValid_o = valid_q;
   assign ParityErr_o = perr_q;
   assign FrameErr_o  = ferr_q;
   assign Overrun_o   = ovr_q;

endmodule

// File: tb/tb_rx_frame_fsm.sv
// Directed bench for rx_frame_fsm: 8N1 and 8E1 instances, table of frames
// plus hand sequences for glitch, overrun/ack and mid-frame reset.
module tb_rx_frame_fsm;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       acq = 1'b0;
   logic       sync = 1'b0;
   logic       rxb = 1'b1;
   logic       ack = 1'b0;

   logic [4:0] st0, st1;
   logic [7:0] d0, d1;
   logic       v0, v1, pe0, pe1, fe0, fe1, ov0, ov1;

   bit         sel = 1'b0;
   logic [4:0] s_st;
   logic [7:0] s_d;
   logic       s_v, s_pe, s_fe, s_ov;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   rx_frame_fsm u_dut0 (
      .clk(clk), .rst(rst), .AcqSig_i(acq), .Rx_Synch_i(sync),
      .RxBit_i(rxb), .State_o(st0), .Data_o(d0), .DataValid_o(v0),
      .DataAck_i(ack), .ParityErr_o(pe0), .FrameErr_o(fe0),
      .Overrun_o(ov0)
   );

   rx_frame_fsm #(.PARITY_EN(1), .PARITY_ODD(0)) u_dut1 (
      .clk(clk), .rst(rst), .AcqSig_i(acq), .Rx_Synch_i(sync),
      .RxBit_i(rxb), .State_o(st1), .Data_o(d1), .DataValid_o(v1),
      .DataAck_i(ack), .ParityErr_o(pe1), .FrameErr_o(fe1),
      .Overrun_o(ov1)
   );

   assign s_st = sel ? st1 : st0;
   assign s_d  = sel ? d1 : d0;
   assign s_v  = sel ? v1 : v0;
   assign s_pe = sel ? pe1 : pe0;
   assign s_fe = sel ? fe1 : fe0;
   assign s_ov = sel ? ov1 : ov0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // One acquisition pulse followed by one quiet cycle.
   task automatic pulse(input bit s, input bit r, input bit a);
      acq = 1'b1; sync = s; rxb = r; ack = a;
      @(posedge clk); #1;
      acq = 1'b0; sync = 1'b0; ack = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, " state"}, 32'(s_st), 32'h0);
      chk({tag, " data"},  32'(s_d),  32'h0);
      chk({tag, " valid"}, 32'(s_v),  32'h0);
      chk({tag, " perr"},  32'(s_pe), 32'h0);
      chk({tag, " ferr"},  32'(s_fe), 32'h0);
      chk({tag, " ovr"},   32'(s_ov), 32'h0);
   endtask

   task automatic send_frame(input string tag, input logic [7:0] d,
                             input bit pe, input bit pb, input bit sb,
                             input int sync_at, input bit ack_end,
                             input bit prev_v, input bit xperr,
                             input bit xferr);
      int last;
      int stop_at;
      last    = 16 * (9 + int'(pe)) + 8;
      stop_at = 16 * (9 + int'(pe)) - 1;
      sel     = pe;
      for (int k = 0; k <= last; k++) begin
         int bi;
         bit r;
         bi = k / 16;
         if (bi == 0)            r = 1'b0;
         else if (bi <= 8)       r = d[bi-1];
         else if (pe && bi == 9) r = pb;
         else                    r = sb;
         pulse((k == 0) || (k == sync_at), r, ack_end && (k == last));
         if (k == 0)  chk({tag, " st start"}, 32'(s_st), 32'h01);
         if (k == 15) chk({tag, " st data"},  32'(s_st), 32'h02);
         if (pe && k == 143)
            chk({tag, " st parity"}, 32'(s_st), 32'h04);
         if (k == stop_at) chk({tag, " st stop"}, 32'(s_st), 32'h08);
         if (k == last - 1)
            chk({tag, " valid early"}, 32'(s_v), 32'(prev_v));
      end
      rxb = 1'b1;
      chk({tag, " valid"}, 32'(s_v),  32'h1);
      chk({tag, " data"},  32'(s_d),  32'(d));
      chk({tag, " state"}, 32'(s_st), 32'h0);
      chk({tag, " perr"},  32'(s_pe), 32'(xperr));
      chk({tag, " ferr"},  32'(s_fe), 32'(xferr));
   endtask

   typedef struct {
      logic [7:0] d;
      bit         pe;
      bit         pb;
      bit         sb;
      int         sync_at;
      bit         perr;
      bit         ferr;
   } vec_t;

   vec_t tv[7];

   initial begin
      tv[0] = '{8'hA5, 1'b0, 1'b0, 1'b1, -1, 1'b0, 1'b0};
      tv[1] = '{8'h3C, 1'b0, 1'b0, 1'b0, -1, 1'b0, 1'b1};
      tv[2] = '{8'hA5, 1'b1, 1'b0, 1'b1, -1, 1'b0, 1'b0};
      tv[3] = '{8'hA5, 1'b1, 1'b1, 1'b1, -1, 1'b1, 1'b0};
      tv[4] = '{8'h01, 1'b1, 1'b1, 1'b1, -1, 1'b0, 1'b0};
      tv[5] = '{8'hC3, 1'b0, 1'b0, 1'b1, 40, 1'b0, 1'b0};
      tv[6] = '{8'h5A, 1'b1, 1'b1, 1'b0, -1, 1'b1, 1'b1};

      @(posedge clk); #1;

      for (int i = 0; i < 7; i++) begin
         sel = tv[i].pe;
         do_reset();
         chk_zero($sformatf("v%0d rst", i));
         send_frame($sformatf("v%0d", i), tv[i].d, tv[i].pe, tv[i].pb,
                    tv[i].sb, tv[i].sync_at, 1'b0, 1'b0,
                    tv[i].perr, tv[i].ferr);
      end

      // False start: line high at the START mid tick.
      sel = 1'b0;
      do_reset();
      pulse(1'b1, 1'b0, 1'b0);
      chk("glitch start", 32'(s_st), 32'h01);
      for (int k = 1; k < 8; k++) pulse(1'b0, 1'b0, 1'b0);
      pulse(1'b0, 1'b1, 1'b0);
      chk("glitch idle", 32'(s_st), 32'h00);
      for (int k = 0; k < 20; k++) pulse(1'b0, 1'b1, 1'b0);
      chk("glitch hold", 32'(s_st), 32'h00);
      chk("glitch valid", 32'(s_v), 32'h0);

      // Back-to-back frames without ack, then ack handling.
      do_reset();
      send_frame("b2b1", 8'h11, 1'b0, 1'b0, 1'b1, -1, 1'b0, 1'b0,
                 1'b0, 1'b0);
      chk("b2b1 ovr", 32'(s_ov), 32'h0);
      pulse(1'b0, 1'b1, 1'b0);
      send_frame("b2b2", 8'h22, 1'b0, 1'b0, 1'b1, -1, 1'b0, 1'b1,
                 1'b0, 1'b0);
      chk("b2b2 ovr", 32'(s_ov), 32'h1);
      ack = 1'b1;
      @(posedge clk); #1;
      ack = 1'b0;
      chk("ack valid", 32'(s_v),  32'h0);
      chk("ack ovr",   32'(s_ov), 32'h0);
      ack = 1'b1;
      @(posedge clk); #1;
      ack = 1'b0;
      chk("idle ack valid", 32'(s_v), 32'h0);
      chk("idle ack data",  32'(s_d), 32'h22);
      send_frame("f44", 8'h44, 1'b0, 1'b0, 1'b1, -1, 1'b0, 1'b0,
                 1'b0, 1'b0);
      send_frame("f55", 8'h55, 1'b0, 1'b0, 1'b1, -1, 1'b0, 1'b1,
                 1'b0, 1'b0);
      chk("f55 ovr", 32'(s_ov), 32'h1);
      send_frame("f33", 8'h33, 1'b0, 1'b0, 1'b1, -1, 1'b1, 1'b1,
                 1'b0, 1'b0);
      chk("coinc ovr", 32'(s_ov), 32'h0);

      // Reset during DATA bit 3, then a clean frame.
      pulse(1'b1, 1'b0, 1'b0);
      for (int k = 1; k <= 68; k++) pulse(1'b0, k[4], 1'b0);
      chk("pre-rst st", 32'(s_st), 32'h02);
      do_reset();
      chk_zero("midrst");
      send_frame("post", 8'h5A, 1'b0, 1'b0, 1'b1, -1, 1'b0, 1'b0,
                 1'b0, 1'b0);
      chk("post ovr", 32'(s_ov), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
